// File: rtl/counter_bus_ctrl_if.sv
// -----------------------------------------------------------------------------
// counter_bus_ctrl_if
// CPU-side memory-mapped bus used to reach the three-channel counter
// peripheral through counter_bus_ctrl.
//
// Signals
//   mem_w    : single-cycle store request pulse (CPU -> controller)
//   mem_r    : single-cycle load request pulse  (CPU -> controller)
//   addr     : word select, 0-2 = channel 0-2, 3 = CTRL
//   data_in  : store data
//   data_out : load data, valid while ready=1 and held afterwards
//   ready    : one-cycle completion pulse
//   busy     : controller is not idle
//
// Modports
//   master : CPU side
//   slave  : controller side
// -----------------------------------------------------------------------------
interface counter_bus_ctrl_if;
   logic        mem_w;
   logic        mem_r;
   logic [1:0]  addr;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        ready;
   logic        busy;

   modport master (
      output mem_w, mem_r, addr, data_in,
      input  data_out, ready, busy
   );

   modport slave (
      input  mem_w, mem_r, addr, data_in,
      output data_out, ready, busy
   );
endinterface

// File: rtl/counter_bus_ctrl.sv
// -----------------------------------------------------------------------------
// counter_bus_ctrl
// CPU-side controller for the three-channel counter peripheral.
//   - Decodes load/store requests from the CPU bus (accepted only when idle;
//     a simultaneous store and load is treated as a store).
//   - Drives the counter write port, holding counter_we for WE_CYCLES cycles
//     so the slow counter clocks can capture it.
//   - For channel reads, drives counter_ch and waits RD_WAIT cycles for the
//     readback to settle before latching counter_out into data_out.
//   - Optional interrupt block (macro COUNTER_IRQ_EN): two-flop synchronizers
//     on the terminal-count flags, sticky status bits with write-1-to-clear,
//     interrupt enables, and a registered level irq. Without the macro, irq
//     is tied low, CTRL reads return 0 and CTRL writes are ignored.
//
// Parameters
//   WE_CYCLES : cycles counter_we is held per channel write (1-15)
//   RD_WAIT   : cycles from counter_ch to latching counter_out (1-15)
//
// Ports
//   clk          : system clock, rising edge
//   reset_n      : asynchronous active-low reset
//   bus          : CPU bus (slave side of counter_bus_ctrl_if)
//   counter_we   : counter write enable
//   counter_ch   : counter channel select (held between accesses)
//   counter_val  : counter load value (held between accesses)
//   counter_out  : readback of the selected channel
//   counter0_out : channel 0 terminal-count flag (asynchronous)
//   counter1_out : channel 1 terminal-count flag (asynchronous)
//   counter2_out : channel 2 terminal-count flag (asynchronous)
//   irq          : level interrupt request
// -----------------------------------------------------------------------------
module counter_bus_ctrl #(
   parameter int WE_CYCLES = 4,
   parameter int RD_WAIT   = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   counter_bus_ctrl_if.slave  bus,
   output logic               counter_we,
   output logic [1:0]         counter_ch,
   output logic [31:0]        counter_val,
   input  logic [31:0]        counter_out,
   input  logic               counter0_out,
   input  logic               counter1_out,
   input  logic               counter2_out,
   output logic               irq
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] CTRL_ADDR = 2'd3;

   // Counters are loaded with N-1 and the terminal action fires on 0, giving
   // exactly N cycles in WRITE / READ.
   localparam logic [3:0] WE_LOAD = 4'(WE_CYCLES - 1);
   localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);

   state_t      state, state_d;
   logic [3:0]  cnt, cnt_d;
   logic        counter_we_d;
   logic [1:0]  counter_ch_d;
   logic [31:0] counter_val_d;
   logic [31:0] data_out, data_out_d;
   logic        ctrl_wr;      // CTRL store accepted this cycle
   logic [31:0] ctrl_rdata;   // value a CTRL load returns

   // ---------------------------------------------------------------------------
   // Next-state and datapath logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it
      // unassigned and no latch is inferred.
      state_d       = state;
      cnt_d         = cnt;
      counter_we_d  = counter_we;
      counter_ch_d  = counter_ch;
      counter_val_d = counter_val;
      data_out_d    = data_out;
      ctrl_wr       = 1'b0;

      case (state)
         IDLE: begin
            if (bus.mem_w) begin
               if (bus.addr == CTRL_ADDR) begin
                  ctrl_wr = 1'b1;
                  state_d = DONE;
               end else begin
                  counter_ch_d  = bus.addr;
                  counter_val_d = bus.data_in;
                  counter_we_d  = 1'b1;
                  cnt_d         = WE_LOAD;
                  state_d       = WRITE;
               end
            end else if (bus.mem_r) begin
               if (bus.addr == CTRL_ADDR) begin
                  data_out_d = ctrl_rdata;
                  state_d    = DONE;
               end else begin
                  counter_ch_d = bus.addr;
                  cnt_d        = RD_LOAD;
                  state_d      = READ;
               end
            end
         end

         WRITE: begin
            if (cnt == 4'd0) begin
               counter_we_d = 1'b0;
               state_d      = DONE;
            end else begin
               cnt_d = cnt - 4'd1;
            end
         end

         READ: begin
            if (cnt == 4'd0) begin
               data_out_d = counter_out;
               state_d    = DONE;
            end else begin
               cnt_d = cnt - 4'd1;
            end
         end

         DONE: state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         counter_we  <= 1'b0;
         counter_ch  <= 2'd0;
         counter_val <= 32'd0;
         data_out    <= 32'd0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state       <= state_d;
         cnt         <= cnt_d;
         counter_we  <= counter_we_d;
         counter_ch  <= counter_ch_d;
         counter_val <= counter_val_d;
         data_out    <= data_out_d;
      end
   end

   assign bus.data_out = data_out;
   assign bus.ready    = (state == DONE);
   assign bus.busy     = (state != IDLE);

   // ---------------------------------------------------------------------------
   // Interrupt block
   // ---------------------------------------------------------------------------
`ifdef COUNTER_IRQ_EN
   logic [2:0] sync1, sync2, sync3;   // sync1/sync2 synchronize, sync3 detects edges
   logic [2:0] ien, stat;
   logic [2:0] flag_rise, w1c;

   assign flag_rise  = sync2 & ~sync3;
   assign w1c        = ctrl_wr ? bus.data_in[6:4] : 3'b000;
   assign ctrl_rdata = {25'd0, stat, 1'b0, ien};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 3'b000;
         sync2 <= 3'b000;
         sync3 <= 3'b000;
         ien   <= 3'b000;
         stat  <= 3'b000;
         irq   <= 1'b0;
      end else begin
         sync1 <= {counter2_out, counter1_out, counter0_out};
         sync2 <= sync1;
         sync3 <= sync2;
         if (ctrl_wr) begin
            ien <= bus.data_in[2:0];
         end
         // Clear is applied first so a same-cycle flag edge wins.
         stat  <= (stat & ~w1c) | flag_rise;
         irq   <= |(stat & ien);
      end
   end
`else
   logic unused_ok;

   assign irq        = 1'b0;
   assign ctrl_rdata = 32'd0;
   assign unused_ok  = ^{counter0_out, counter1_out, counter2_out, ctrl_wr};
`endif

endmodule

// File: tb/tb_counter_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_bus_ctrl
// Self-checking bench for counter_bus_ctrl. A driver issues directed and
// random bus transactions and pushes the expected completion (ready cycle
// and data_out) into a queue; a monitor pops and compares whenever ready is
// seen. A second monitor checks each counter_we pulse (length, channel,
// value). Expectations come from a small transaction-level model of the
// CTRL register state, honouring COUNTER_IRQ_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_counter_bus_ctrl;

   localparam int WE_CYCLES = 4;
   localparam int RD_WAIT   = 2;

`ifdef COUNTER_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic [1:0]  ch;
      logic [31:0] val;
   } we_t;

   logic        clk;
   logic        reset_n;
   logic        counter_we;
   logic [1:0]  counter_ch;
   logic [31:0] counter_val;
   logic [31:0] counter_out;
   logic [2:0]  flags;
   logic        irq;

   counter_bus_ctrl_if bus ();

   counter_bus_ctrl #(
      .WE_CYCLES (WE_CYCLES),
      .RD_WAIT   (RD_WAIT)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .bus          (bus),
      .counter_we   (counter_we),
      .counter_ch   (counter_ch),
      .counter_val  (counter_val),
      .counter_out  (counter_out),
      .counter0_out (flags[0]),
      .counter1_out (flags[1]),
      .counter2_out (flags[2]),
      .irq          (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   int errors = 0;
   int checks = 0;

   exp_t exp_q[$];
   we_t  we_q[$];

   // Reference model state
   logic [2:0]  ien_m  = 3'b000;
   logic [2:0]  stat_m = 3'b000;
   logic [31:0] do_m   = 32'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ctrl_model();
      return IRQ_EN ? {25'd0, stat_m, 1'b0, ien_m} : 32'd0;
   endfunction

   function automatic logic irq_model();
      return IRQ_EN && (|(stat_m & ien_m));
   endfunction

   // ---------------------------------------------------------------------------
   // Monitors
   // ---------------------------------------------------------------------------
   exp_t exp_e;
   always @(negedge clk) begin
      if (reset_n && bus.ready) begin
         check("ready_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            exp_e = exp_q.pop_front();
            check("ready_cycle", 32'(cyc), 32'(exp_e.cyc));
            check("data_out", bus.data_out, exp_e.data);
         end
      end
   end

   int  we_run = 0;
   we_t we_e;
   always @(negedge clk) begin
      if (!reset_n) begin
         we_run = 0;
      end else if (counter_we) begin
         we_run++;
      end else if (we_run > 0) begin
         check("we_expected", 32'(we_q.size() != 0), 32'd1);
         if (we_q.size() != 0) begin
            we_e = we_q.pop_front();
            check("we_length", 32'(we_run), 32'(WE_CYCLES));
            check("counter_ch", 32'(counter_ch), 32'(we_e.ch));
            check("counter_val", counter_val, we_e.val);
         end
         we_run = 0;
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         bus.mem_w = 1'b0;
         bus.mem_r = 1'b0;
      end
   endtask

   // One bus transaction. The expected completion is queued for the monitor.
   // When stray is set, one extra request pulse is driven during a busy cycle
   // (WRITE/READ/DONE); it must be dropped.
   task automatic issue(input bit w, input bit r, input logic [1:0] a,
                        input logic [31:0] d, input logic [31:0] rdval, input bit stray);
      int   t;
      int   lat;
      int   ts;
      bit   got;
      exp_t e;
      @(posedge clk);
      #1;
      bus.mem_w   = w;
      bus.mem_r   = r;
      bus.addr    = a;
      bus.data_in = d;
      counter_out = $urandom;
      t = cyc;
      if (w) begin
         if (a == 2'd3) begin
            lat = 1;
            if (IRQ_EN) begin
               ien_m  = d[2:0];
               stat_m = stat_m & ~d[6:4];
            end
         end else begin
            lat = WE_CYCLES + 1;
            we_q.push_back('{ch: a, val: d});
         end
      end else begin
         if (a == 2'd3) begin
            lat  = 1;
            do_m = ctrl_model();
         end else begin
            lat  = RD_WAIT + 1;
            do_m = rdval;
         end
      end
      e.cyc  = t + lat;
      e.data = do_m;
      exp_q.push_back(e);
      ts  = t + 1 + $urandom_range(0, lat - 1);
      got = 1'b0;
      for (int n = 0; n < 60; n++) begin
         @(posedge clk);
         #1;
         bus.mem_w = 1'b0;
         bus.mem_r = 1'b0;
         if (cyc == t + 1) counter_out = rdval;
         else if (cyc == t + RD_WAIT + 1) counter_out = ~rdval;
         if (stray && cyc == ts) begin
            bus.mem_w   = $urandom_range(0, 1) == 1;
            bus.mem_r   = 1'b1;
            bus.addr    = 2'($urandom_range(0, 3));
            bus.data_in = $urandom;
         end
         if (bus.ready) begin
            got = 1'b1;
            break;
         end
      end
      check("ready_seen", 32'(got), 32'd1);
   endtask

   // irq follows a CTRL store by one cycle.
   task automatic check_irq();
      idle(1);
      check("irq_after_ctrl", 32'(irq), 32'(irq_model()));
   endtask

   // Raise a flag and check irq at the exact cycle it may change.
   task automatic raise_flag(input int n);
      logic irq_old;
      irq_old = irq_model();
      @(posedge clk);
      #1;
      bus.mem_w = 1'b0;
      bus.mem_r = 1'b0;
      flags[n]  = 1'b1;
      idle(3);
      check("irq_before_flag", 32'(irq), 32'(irq_old));
      if (IRQ_EN) stat_m[n] = 1'b1;
      idle(1);
      check("irq_after_flag", 32'(irq), 32'(irq_model()));
      flags[n] = 1'b0;
      idle(3);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_counter_we"},  32'(counter_we), 32'd0);
      check({tag, "_counter_ch"},  32'(counter_ch), 32'd0);
      check({tag, "_counter_val"}, counter_val, 32'd0);
      check({tag, "_data_out"},    bus.data_out, 32'd0);
      check({tag, "_ready"},       32'(bus.ready), 32'd0);
      check({tag, "_busy"},        32'(bus.busy), 32'd0);
      check({tag, "_irq"},         32'(irq), 32'd0);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int          kind;
      logic [1:0]  ch;
      logic [31:0] d;
      bit          s;

      reset_n     = 1'b0;
      bus.mem_w   = 1'b0;
      bus.mem_r   = 1'b0;
      bus.addr    = 2'd0;
      bus.data_in = 32'd0;
      counter_out = 32'd0;
      flags       = 3'b000;
      #1;
      check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Channel write then read
      issue(1'b1, 1'b0, 2'd1, 32'h0000_1234, 32'd0, 1'b0);
      issue(1'b0, 1'b1, 2'd2, 32'd0, 32'hDEAD_BEEF, 1'b0);
      // Dropped request during a write
      issue(1'b1, 1'b0, 2'd0, 32'hCAFE_0001, 32'd0, 1'b1);
      // Simultaneous store and load: store wins
      issue(1'b1, 1'b1, 2'd0, 32'h5555_AAAA, 32'h1111_2222, 1'b0);

      // Interrupt enable, flag, clear
      issue(1'b1, 1'b0, 2'd3, 32'h0000_0001, 32'd0, 1'b0);
      check_irq();
      raise_flag(0);
      issue(1'b0, 1'b1, 2'd3, 32'd0, 32'd0, 1'b0);
      issue(1'b1, 1'b0, 2'd3, 32'h0000_0011, 32'd0, 1'b0);
      check_irq();
      issue(1'b0, 1'b1, 2'd3, 32'd0, 32'd0, 1'b0);

      // Set wins over a same-cycle clear: flag edge reaches stat at the third
      // edge after it is raised, exactly where the CTRL store is sampled.
      @(posedge clk);
      #1;
      flags[0] = 1'b1;
      idle(1);
      issue(1'b1, 1'b0, 2'd3, 32'h0000_0011, 32'd0, 1'b0);
      if (IRQ_EN) stat_m[0] = 1'b1;
      check_irq();
      issue(1'b0, 1'b1, 2'd3, 32'd0, 32'd0, 1'b0);
      flags[0] = 1'b0;
      idle(3);

      // Randomized traffic
      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 5);
         ch   = 2'($urandom_range(0, 2));
         d    = $urandom;
         s    = ($urandom_range(0, 2) == 0);
         case (kind)
            0: issue(1'b1, 1'b0, ch,   d, $urandom, s);
            1: issue(1'b0, 1'b1, ch,   d, $urandom, s);
            2: issue(1'b1, 1'b0, 2'd3, d, $urandom, s);
            3: issue(1'b0, 1'b1, 2'd3, d, $urandom, s);
            4: issue(1'b1, 1'b1, ch,   d, $urandom, s);
            default: raise_flag($urandom_range(0, 2));
         endcase
         if (kind == 2) check_irq();
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end

      // Reset in the second WRITE cycle: no ready, everything back to reset
      @(posedge clk);
      #1;
      bus.mem_w   = 1'b1;
      bus.addr    = 2'd2;
      bus.data_in = 32'h0BAD_F00D;
      idle(2);
      check("we_before_reset", 32'(counter_we), 32'd1);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midwrite_reset");
      ien_m  = 3'b000;
      stat_m = 3'b000;
      do_m   = 32'd0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      idle(3);
      issue(1'b0, 1'b1, 2'd3, 32'd0, 32'd0, 1'b0);

      idle(4);
      check("pending_ready", 32'(exp_q.size()), 32'd0);
      check("pending_we", 32'(we_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
      $fatal(1, "watchdog");
   end

endmodule
